bus_ram_responder: RTL and testbench

- Bus responder (target end) for the CPU's single-port request/ready bus; serves word reads and writes from an internal synchronous RAM.
- Sits behind the CPU bus (or a bus interconnect port) as main/boot memory.
- Inserts a programmable number of wait states so initiator stall paths (fetch and memory stages) are exercised.

---
 rtl/bus_pkg.sv | 32 +++
 rtl/bus_ram_responder_if.sv | 39 +++
 rtl/bus_ram_sp.sv | 36 +++
 rtl/bus_ram_responder.sv | 167 ++++++++++++++++
 tb/tb_bus_ram_responder.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the bus RAM responder:
//   - bus_state_t    : responder FSM state encoding (2 bits)
//   - BUS_READ/WRITE : encoding of the bus rw signal
//   - DATA_WIDTH     : bus / RAM word width
//   - WORD_LSB       : lowest byte-address bit that forms the word index
//   - WAIT_CNT_WIDTH : width of the wait-state counter (0..15 wait states)
// ---------------------------------------------------------------------------
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } bus_state_t;

  localparam logic BUS_READ  = 1'b0;
  localparam logic BUS_WRITE = 1'b1;

  localparam int DATA_WIDTH     = 32;
  localparam int WORD_LSB       = 2;
  localparam int WAIT_CNT_WIDTH = 4;

  // Most significant byte-address bit of the word index for a RAM with
  // 2**addr_width words.
  function automatic int word_msb(input int addr_width);
    return addr_width + WORD_LSB - 1;
  endfunction

endpackage

// File: rtl/bus_ram_responder_if.sv
// ---------------------------------------------------------------------------
// bus_ram_responder_if
// CPU request/ready bus, 4-phase handshake.
//   i_bus_rw       : 0 = read, 1 = write
//   i_bus_request  : access request from initiator
//   o_bus_ready    : access complete
//   i_bus_address  : byte address
//   i_bus_wdata    : write data
//   o_bus_rdata    : read data
// Modports: master (initiator side), slave (responder side).
// ---------------------------------------------------------------------------
interface bus_ram_responder_if;

  logic        i_bus_rw;
  logic        i_bus_request;
  logic        o_bus_ready;
  logic [31:0] i_bus_address;
  logic [31:0] i_bus_wdata;
  logic [31:0] o_bus_rdata;

  modport master (
    output i_bus_rw,
    output i_bus_request,
    output i_bus_address,
    output i_bus_wdata,
    input  o_bus_ready,
    input  o_bus_rdata
  );

  modport slave (
    input  i_bus_rw,
    input  i_bus_request,
    input  i_bus_address,
    input  i_bus_wdata,
    output o_bus_ready,
    output o_bus_rdata
  );

endinterface

// File: rtl/bus_ram_sp.sv
// ---------------------------------------------------------------------------
// bus_ram_sp
// Single-port synchronous RAM with registered read data, written so that it
// infers a block RAM. Contents are never reset.
//   clock : rising-edge clock
//   en    : access enable for this cycle
//   we    : 1 = write wdata to addr, 0 = read addr into rdata
//   addr  : word address
//   wdata : write data
//   rdata : registered read data, updated only on enabled reads
// ---------------------------------------------------------------------------
module bus_ram_sp #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/bus_ram_responder.sv
// ---------------------------------------------------------------------------
// bus_ram_responder
// Target end of the CPU request/ready bus serving 32-bit word reads and
// writes from an internal synchronous RAM, with WAIT_STATES extra cycles
// inserted before each RAM access.
//   i_clock : rising-edge clock
//   i_reset : asynchronous reset, active low
//   bus     : bus_ram_responder_if.slave (rw, request, ready, address,
//             wdata, rdata)
// Optional: define BUS_RAM_RESPONDER_STATS_EN to add o_read_count and
// o_write_count, counting completed reads and writes since reset.
// Parameters:
//   ADDR_WIDTH  : word-address bits, RAM depth 2**ADDR_WIDTH words
//   WAIT_STATES : extra cycles before the RAM access (0..15)
// ---------------------------------------------------------------------------
module bus_ram_responder
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  bus_ram_responder_if.slave   bus
`ifdef BUS_RAM_RESPONDER_STATS_EN
  ,
  output logic [31:0]          o_read_count,
  output logic [31:0]          o_write_count
`endif
);

  localparam int IDX_MSB = word_msb(ADDR_WIDTH);
  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD = WAIT_CNT_WIDTH'(WAIT_STATES);
  localparam logic [WAIT_CNT_WIDTH-1:0] CNT_ONE   = WAIT_CNT_WIDTH'(1);

  bus_state_t state, next_state;

  logic [WAIT_CNT_WIDTH-1:0] wait_cnt, cnt_d;
  logic                      ready, ready_d;
  logic [DATA_WIDTH-1:0]     rdata;
  logic                      latch_req;
  logic                      load_rdata;

  logic                      lat_rw;
  logic [ADDR_WIDTH-1:0]     lat_idx;
  logic [DATA_WIDTH-1:0]     lat_wdata;

  logic                      ram_en;
  logic                      ram_we;
  logic [DATA_WIDTH-1:0]     ram_rdata;

  // Byte-lane bits and bits above the RAM index are ignored, so addresses
  // alias modulo the RAM size.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.i_bus_address[WORD_LSB-1:0],
                              bus.i_bus_address[31:IDX_MSB+1]};

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      ready     <= 1'b0;
      rdata     <= '0;
      lat_rw    <= BUS_READ;
      lat_idx   <= '0;
      lat_wdata <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= cnt_d;
      ready    <= ready_d;
      if (latch_req) begin
        lat_rw    <= bus.i_bus_rw;
        lat_idx   <= bus.i_bus_address[IDX_MSB:WORD_LSB];
        lat_wdata <= bus.i_bus_wdata;
      end
      if (load_rdata) begin
        rdata <= ram_rdata;
      end
    end
  end

  // DONE always raises ready for at least one cycle and only leaves once
  // ready has been seen high together with request low. This keeps ready
  // up until the initiator lets go, and still gives a one-cycle pulse when
  // the initiator dropped request before the access finished.
  // Read data is captured from the RAM's output register on the first DONE
  // cycle, the same edge that raises ready.
  always_comb begin
    next_state = state;
    cnt_d      = wait_cnt;
    ready_d    = 1'b0;
    latch_req  = 1'b0;
    load_rdata = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.i_bus_request) begin
          latch_req = 1'b1;
          if (WAIT_STATES > 0) begin
            next_state = ST_WAIT;
            cnt_d      = WAIT_LOAD;
          end else begin
            next_state = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt <= CNT_ONE) begin
          next_state = ST_ACCESS;
          cnt_d      = '0;
        end else begin
          cnt_d = wait_cnt - CNT_ONE;
        end
      end
      ST_ACCESS: begin
        next_state = ST_DONE;
      end
      ST_DONE: begin
        load_rdata = !ready && (lat_rw == BUS_READ);
        if (ready && !bus.i_bus_request) begin
          next_state = ST_IDLE;
        end else begin
          ready_d = 1'b1;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  assign ram_en = (state == ST_ACCESS);
  assign ram_we = (lat_rw == BUS_WRITE);

  bus_ram_sp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clock (i_clock),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (lat_idx),
    .wdata (lat_wdata),
    .rdata (ram_rdata)
  );

  assign bus.o_bus_ready = ready;
  assign bus.o_bus_rdata = rdata;

`ifdef BUS_RAM_RESPONDER_STATS_EN
  // Each access is counted once, on its ACCESS cycle; counters wrap.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_read_count  <= '0;
      o_write_count <= '0;
    end else if (state == ST_ACCESS) begin
      if (lat_rw == BUS_WRITE) begin
        o_write_count <= o_write_count + 32'd1;
      end else begin
        o_read_count <= o_read_count + 32'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_bus_ram_responder.sv
// ---------------------------------------------------------------------------
// tb_bus_ram_responder
// Three responders with WAIT_STATES = 1, 0 and 3 share one initiator; sel
// routes the request to one of them. The stimulus task queues the expected
// read data and ready latency; a monitor pops and compares whenever the
// selected responder raises ready.
// ---------------------------------------------------------------------------
module tb_bus_ram_responder;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rw;
  logic        req;
  logic [31:0] addr;
  logic [31:0] wdata;
  int          sel;

  exp_t        exp_q[$];
  logic [31:0] last_rd [3];
  int          total = 0;
  int          bad   = 0;

  logic        ready_sel;
  logic [31:0] rdata_sel;

  always #5 clk = ~clk;

  bus_ram_responder_if bus_a ();
  bus_ram_responder_if bus_b ();
  bus_ram_responder_if bus_c ();

  assign bus_a.i_bus_rw      = rw;
  assign bus_a.i_bus_address = addr;
  assign bus_a.i_bus_wdata   = wdata;
  assign bus_a.i_bus_request = req && (sel == 0);
  assign bus_b.i_bus_rw      = rw;
  assign bus_b.i_bus_address = addr;
  assign bus_b.i_bus_wdata   = wdata;
  assign bus_b.i_bus_request = req && (sel == 1);
  assign bus_c.i_bus_rw      = rw;
  assign bus_c.i_bus_address = addr;
  assign bus_c.i_bus_wdata   = wdata;
  assign bus_c.i_bus_request = req && (sel == 2);

  assign ready_sel = (sel == 0) ? bus_a.o_bus_ready :
                     (sel == 1) ? bus_b.o_bus_ready : bus_c.o_bus_ready;
  assign rdata_sel = (sel == 0) ? bus_a.o_bus_rdata :
                     (sel == 1) ? bus_b.o_bus_rdata : bus_c.o_bus_rdata;

`ifdef BUS_RAM_RESPONDER_STATS_EN
  logic [31:0] rc_a, wc_a, rc_b, wc_b, rc_c, wc_c;
`endif

  bus_ram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) dut_a (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus_a)
`ifdef BUS_RAM_RESPONDER_STATS_EN
    , .o_read_count (rc_a), .o_write_count (wc_a)
`endif
  );

  bus_ram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut_b (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus_b)
`ifdef BUS_RAM_RESPONDER_STATS_EN
    , .o_read_count (rc_b), .o_write_count (wc_b)
`endif
  );

  bus_ram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) dut_c (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus_c)
`ifdef BUS_RAM_RESPONDER_STATS_EN
    , .o_read_count (rc_c), .o_write_count (wc_c)
`endif
  );

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 0 : 3;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // hold >= 0 : keep request up for hold extra cycles after ready, then drop
  // hold <  0 : drop request one cycle after it was first sampled
  // scramble  : corrupt rw/address/wdata right after the request is latched
  task automatic applyStimulus(input int d, input logic w, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] exp_rd,
                               input int hold, input bit scramble);
    exp_t e;
    int   n;
    int   pulse;
    e.rdata = w ? last_rd[d] : exp_rd;
    e.lat   = ws_of(d) + 3;
    if (!w) last_rd[d] = exp_rd;
    exp_q.push_back(e);
    @(posedge clk); #1;
    sel = d; rw = w; addr = a; wdata = wd; req = 1'b1;
    @(posedge clk); #1;
    if (scramble) begin
      rw = ~w; addr = ~a; wdata = ~wd;
    end
    if (hold < 0) req = 1'b0;
    n = 0;
    while (!ready_sel && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_seen", 32'(ready_sel), 32'd1);
    if (hold < 0) begin
      pulse = 0;
      while (ready_sel && pulse < 10) begin
        pulse++;
        @(negedge clk);
      end
      checkOutput("pulse_width", 32'(pulse), 32'd1);
    end else begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        checkOutput("ready_held", 32'(ready_sel), 32'd1);
      end
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      checkOutput("ready_until_drop_sampled", 32'(ready_sel), 32'd1);
      @(negedge clk);
      checkOutput("ready_clear", 32'(ready_sel), 32'd0);
    end
    @(negedge clk);
    checkOutput("ready_idle", 32'(ready_sel), 32'd0);
  endtask

  // Scoreboard monitor: latency counts negedges since request first rose.
  initial begin
    exp_t e;
    logic prev_req   = 1'b0;
    logic prev_ready = 1'b0;
    int   lat_cnt    = 0;
    forever begin
      @(negedge clk);
      if (req && !prev_req) lat_cnt = 0;
      else lat_cnt = lat_cnt + 1;
      if (ready_sel && !prev_ready) begin
        checkOutput("expect_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkOutput("rdata", rdata_sel, e.rdata);
          checkOutput("latency", 32'(lat_cnt), 32'(e.lat));
        end
      end
      prev_req   = req;
      prev_ready = ready_sel;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    int   n;
    rst_n = 1'b0; req = 1'b0; rw = 1'b0; addr = '0; wdata = '0; sel = 0;
    for (int i = 0; i < 3; i++) last_rd[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready_a", 32'(bus_a.o_bus_ready), 32'd0);
    checkOutput("rst_rdata_a", bus_a.o_bus_rdata, 32'd0);
    checkOutput("rst_ready_b", 32'(bus_b.o_bus_ready), 32'd0);
    checkOutput("rst_ready_c", 32'(bus_c.o_bus_ready), 32'd0);
`ifdef BUS_RAM_RESPONDER_STATS_EN
    checkOutput("rst_read_count", rc_a, 32'd0);
    checkOutput("rst_write_count", wc_a, 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] read after write, 1 wait state");
    applyStimulus(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
    applyStimulus(0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);

    $display("[TB] aliasing and inputs changing after latch");
    applyStimulus(0, 1'b1, 32'h0000_1004, 32'h1234_5678, 32'h0, 0, 1'b1);
    applyStimulus(0, 1'b0, 32'h0000_0004, 32'h0, 32'h1234_5678, 0, 1'b0);
    applyStimulus(0, 1'b0, 32'h0000_0007, 32'h0, 32'h1234_5678, 0, 1'b0);

    $display("[TB] early request drop");
    applyStimulus(0, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 32'h0, -1, 1'b0);
    applyStimulus(0, 1'b0, 32'h0000_0020, 32'h0, 32'hA5A5_A5A5, 0, 1'b0);

    $display("[TB] zero wait states, held request, top word wrap");
    applyStimulus(1, 1'b1, 32'h0000_0004, 32'hCAFE_F00D, 32'h0, 0, 1'b0);
    applyStimulus(1, 1'b0, 32'h0000_0004, 32'h0, 32'hCAFE_F00D, 5, 1'b0);
    applyStimulus(1, 1'b1, 32'h0000_0FFC, 32'h0BAD_C0DE, 32'h0, 0, 1'b0);
    applyStimulus(1, 1'b0, 32'h0000_1FFC, 32'h0, 32'h0BAD_C0DE, 0, 1'b0);

    $display("[TB] reset during wait states");
    applyStimulus(2, 1'b1, 32'h0000_0040, 32'h2222_2222, 32'h0, 0, 1'b0);
    applyStimulus(2, 1'b0, 32'h0000_0040, 32'h0, 32'h2222_2222, 0, 1'b0);
    @(posedge clk); #1;
    sel = 2; rw = 1'b1; addr = 32'h0000_0040; wdata = 32'h1111_1111; req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ready_c", 32'(bus_c.o_bus_ready), 32'd0);
    checkOutput("midrst_rdata_c", bus_c.o_bus_rdata, 32'd0);
    checkOutput("midrst_rdata_a", bus_a.o_bus_rdata, 32'd0);
    req = 1'b0; rw = 1'b0;
    for (int i = 0; i < 3; i++) last_rd[i] = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(2, 1'b0, 32'h0000_0040, 32'h0, 32'h2222_2222, 0, 1'b0);
    applyStimulus(0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);

    $display("[TB] reset while ready is high");
    e.rdata = 32'hCAFE_F00D;
    e.lat   = 3;
    exp_q.push_back(e);
    @(posedge clk); #1;
    sel = 1; rw = 1'b0; addr = 32'h0000_0004; req = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ready_sel && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_seen_b", 32'(ready_sel), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_drops_ready", 32'(bus_b.o_bus_ready), 32'd0);
    checkOutput("rst_clears_rdata", bus_b.o_bus_rdata, 32'd0);
    req = 1'b0;
    for (int i = 0; i < 3; i++) last_rd[i] = '0;
`ifdef BUS_RAM_RESPONDER_STATS_EN
    checkOutput("rst2_read_count", rc_a, 32'd0);
    checkOutput("rst2_write_count", wc_a, 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] three writes, two reads");
    applyStimulus(0, 1'b1, 32'h0000_0100, 32'h0000_0001, 32'h0, 0, 1'b0);
    applyStimulus(0, 1'b1, 32'h0000_0104, 32'h0000_0002, 32'h0, 0, 1'b0);
    applyStimulus(0, 1'b1, 32'h0000_0108, 32'h0000_0003, 32'h0, 0, 1'b0);
    applyStimulus(0, 1'b0, 32'h0000_0104, 32'h0, 32'h0000_0002, 0, 1'b0);
    applyStimulus(0, 1'b0, 32'h0000_0020, 32'h0, 32'hA5A5_A5A5, 0, 1'b0);
`ifdef BUS_RAM_RESPONDER_STATS_EN
    checkOutput("write_count", wc_a, 32'd3);
    checkOutput("read_count", rc_a, 32'd2);
`endif

    repeat (3) @(negedge clk);
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
